// File: rtl/conv3x3_relu_pipeline_if.sv
// Pixel-in / convolution-out bundle for conv3x3_relu_pipeline.
interface conv3x3_relu_pipeline_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 20
) ();
  logic                          enable;
  logic [DATA_WIDTH-1:0]         pixel_in;
  logic                          pixel_valid;
  logic [9*WEIGHT_WIDTH-1:0]     weights;
  logic [WEIGHT_WIDTH-1:0]       bias;
  logic signed [ACC_WIDTH-1:0]   conv_out;
  logic signed [ACC_WIDTH-1:0]   relu_out;
  logic                          valid_out;

  modport master (
    output enable, pixel_in, pixel_valid, weights, bias,
    input  conv_out, relu_out, valid_out
  );

  modport slave (
    input  enable, pixel_in, pixel_valid, weights, bias,
    output conv_out, relu_out, valid_out
  );
endinterface

// File: rtl/conv3x3_relu_pipeline.sv
// Streaming 3x3 convolution + bias + ReLU over a square raster image,
// using two row buffers and a 3x3 shift window, one pixel per clock.
module conv3x3_relu_pipeline #(
  parameter int IMG_WIDTH    = 28,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  conv3x3_relu_pipeline_if.slave   bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(IMG_WIDTH - 1);

  logic [CW-1:0]           col_q, col_d, row_q, row_d;
  logic [DATA_WIDTH-1:0]   line0_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]   line1_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]   win_q [9];
  logic [DATA_WIDTH-1:0]   win_d [9];
  logic                    win_vld_q, win_vld_d;
  logic                    valid_q;
  logic signed [ACC_WIDTH-1:0] conv_q, sum, px, wt;
  logic                    accept;

  assign accept = bus.enable & bus.pixel_valid;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    win_vld_d = accept && (row_q >= CW'(2)) && (col_q >= CW'(2));
  end

  // line1 holds row-2, line0 holds row-1 at the current column
  always_comb begin
    for (int unsigned i = 0; i < 9; i++) win_d[i] = win_q[i];
    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = line1_q[col_q];
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = line0_q[col_q];
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = bus.pixel_in;
    end
  end

  always_comb begin
    px  = '0;
    wt  = '0;
    sum = ACC_WIDTH'($signed(bus.bias));
    for (int unsigned k = 0; k < 9; k++) begin
      px  = ACC_WIDTH'(win_q[k]);
      wt  = ACC_WIDTH'($signed(bus.weights[WEIGHT_WIDTH*k +: WEIGHT_WIDTH]));
      sum = sum + px * wt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      win_vld_q <= 1'b0;
      valid_q   <= 1'b0;
      conv_q    <= '0;
      for (int unsigned i = 0; i < IMG_WIDTH; i++) begin
        line0_q[i] <= '0;
        line1_q[i] <= '0;
      end
      for (int unsigned i = 0; i < 9; i++) win_q[i] <= '0;
    end else if (bus.enable) begin
      col_q     <= col_d;
      row_q     <= row_d;
      win_vld_q <= win_vld_d;
      valid_q   <= win_vld_q;
      if (win_vld_q) conv_q <= sum;
      for (int unsigned i = 0; i < 9; i++) win_q[i] <= win_d[i];
      if (accept) begin
        line1_q[col_q] <= line0_q[col_q];
        line0_q[col_q] <= bus.pixel_in;
      end
    end
  end

  // A pending strobe is held while disabled and shown once enable returns
  assign bus.valid_out = valid_q & bus.enable;
  assign bus.conv_out  = conv_q;
  assign bus.relu_out  = conv_q[ACC_WIDTH-1] ? '0 : conv_q;
endmodule

// File: tb/tb_conv3x3_relu_pipeline.sv
// Randomized self-checking bench for conv3x3_relu_pipeline against a
// direct window-sum reference model.
module tb_conv3x3_relu_pipeline;
  localparam int W    = 28;
  localparam int NPIX = W * W;
  localparam int OUTS = (W - 2) * (W - 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv3x3_relu_pipeline_if #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(20)) bus ();
  conv3x3_relu_pipeline #(.IMG_WIDTH(W), .DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(20))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int img [NPIX];
  int w [9];
  int b;
  int got_conv [$];
  int got_relu [$];
  int exp_q [$];
  int bad_valid = 0;
  int cyc = 0;
  int first_vcyc = -1;
  int acc58 = -1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) begin
      got_conv.push_back(int'($signed(bus.conv_out)));
      got_relu.push_back(int'($signed(bus.relu_out)));
      if (first_vcyc < 0) first_vcyc = cyc;
      if (bus.enable !== 1'b1) bad_valid++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_coeffs();
    logic [31:0] t;
    for (int k = 0; k < 9; k++) begin
      t = w[k];
      bus.weights[8*k +: 8] = t[7:0];
    end
    t = b;
    bus.bias = t[7:0];
  endtask

  task automatic clear_obs();
    got_conv.delete();
    got_relu.delete();
    exp_q.delete();
    first_vcyc = -1;
    bad_valid  = 0;
  endtask

  // Reference: every full 3x3 window of img, top-left at (r-2, c-2)
  task automatic build_expected();
    int s;
    for (int r = 2; r < W; r++)
      for (int c = 2; c < W; c++) begin
        s = b;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            s += img[(r - 2 + dr) * W + (c - 2 + dc)] * w[3 * dr + dc];
        exp_q.push_back(s);
      end
  endtask

  task automatic send_pixels(input int n, input int gap_pct, input int en_off_at);
    for (int i = 0; i < n; i++) begin
      if (i == en_off_at) begin
        bus.enable = 1'b0;
        bus.pixel_valid = 1'b1;
        repeat (6) begin
          bus.pixel_in = 8'($urandom);
          step();
        end
        bus.enable = 1'b1;
      end
      while (int'($urandom_range(99)) < gap_pct) begin
        bus.pixel_valid = 1'b0;
        bus.pixel_in = 8'($urandom);
        step();
      end
      bus.pixel_valid = 1'b1;
      bus.pixel_in = 8'(img[i]);
      step();
      if (i == 58) acc58 = cyc;
    end
    bus.pixel_valid = 1'b0;
  endtask

  task automatic flush();
    bus.pixel_valid = 1'b0;
    repeat (4) step();
  endtask

  task automatic set_const(input int pix, input int wv, input int bv);
    for (int i = 0; i < NPIX; i++) img[i] = pix;
    for (int k = 0; k < 9; k++) w[k] = wv;
    b = bv;
    load_coeffs();
  endtask

  task automatic test_reset();
    bus.enable = 1'b1;
    bus.pixel_valid = 1'b0;
    bus.pixel_in = '0;
    bus.weights = '0;
    bus.bias = '0;
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.conv_out !== 20'sd0 || bus.relu_out !== 20'sd0 || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset: conv=%0d relu=%0d valid=%b, required 0 0 0",
               bus.conv_out, bus.relu_out, bus.valid_out);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_zero_frame();
    clear_obs();
    set_const(0, 0, -10);
    w = '{9, 11, -2, 1, -2, -11, -17, -9, -8};
    load_coeffs();
    send_pixels(NPIX, 0, -1);
    flush();
    checks++;
    if (got_conv.size() != OUTS) begin
      errors++;
      $display("FAIL zero_count: got %0d, required %0d", got_conv.size(), OUTS);
    end
    for (int i = 0; i < got_conv.size(); i++) begin
      checks++;
      if (got_conv[i] != -10 || got_relu[i] != 0) begin
        errors++;
        $display("FAIL zero_val[%0d]: conv %0d relu %0d, required -10 0", i, got_conv[i], got_relu[i]);
      end
    end
  endtask

  task automatic test_ones_frame();
    clear_obs();
    set_const(1, 1, 0);
    send_pixels(NPIX, 0, -1);
    flush();
    checks++;
    if (got_conv.size() != OUTS) begin
      errors++;
      $display("FAIL ones_count: got %0d, required %0d", got_conv.size(), OUTS);
    end
    checks++;
    if (first_vcyc != acc58 + 1) begin
      errors++;
      $display("FAIL ones_latency: first valid cycle %0d, required %0d", first_vcyc, acc58 + 1);
    end
    for (int i = 0; i < got_conv.size(); i++) begin
      checks++;
      if (got_conv[i] != 9 || got_relu[i] != 9) begin
        errors++;
        $display("FAIL ones_val[%0d]: conv %0d relu %0d, required 9 9", i, got_conv[i], got_relu[i]);
      end
    end
  endtask

  task automatic test_extremes();
    int pos_exp;
    int neg_exp;
    pos_exp = 9 * 255 * 127 + 127;
    neg_exp = 9 * 255 * (-128) - 128;
    clear_obs();
    set_const(255, 127, 127);
    send_pixels(NPIX, 0, -1);
    flush();
    checks++;
    if (got_conv.size() != OUTS || got_conv[0] != pos_exp || got_conv[OUTS-1] != pos_exp
        || got_relu[0] != pos_exp) begin
      errors++;
      $display("FAIL max_sum: n=%0d conv %0d, required n=%0d conv %0d",
               got_conv.size(), (got_conv.size() > 0) ? got_conv[0] : 0, OUTS, pos_exp);
    end
    clear_obs();
    set_const(255, -128, -128);
    send_pixels(NPIX, 0, -1);
    flush();
    checks++;
    if (got_conv.size() != OUTS || got_conv[0] != neg_exp || got_conv[OUTS-1] != neg_exp
        || got_relu[OUTS-1] != 0) begin
      errors++;
      $display("FAIL min_sum: n=%0d conv %0d, required n=%0d conv %0d relu 0",
               got_conv.size(), (got_conv.size() > 0) ? got_conv[0] : 0, OUTS, neg_exp);
    end
  endtask

  task automatic test_ramp();
    clear_obs();
    set_const(0, 0, 0);
    for (int i = 0; i < NPIX; i++) img[i] = i % W;
    w[8] = 1;
    load_coeffs();
    send_pixels(NPIX, 0, -1);
    flush();
    checks++;
    if (got_conv.size() != OUTS) begin
      errors++;
      $display("FAIL ramp_count: got %0d, required %0d", got_conv.size(), OUTS);
    end
    for (int i = 0; i < got_conv.size(); i++) begin
      checks++;
      if (got_conv[i] != (i % (W - 2)) + 2) begin
        errors++;
        $display("FAIL ramp_val[%0d]: got %0d, required %0d", i, got_conv[i], (i % (W - 2)) + 2);
      end
    end
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(255));
    for (int k = 0; k < 9; k++) w[k] = int'($urandom_range(255)) - 128;
    b = int'($urandom_range(255)) - 128;
    load_coeffs();
  endtask

  task automatic test_gaps_enable();
    clear_obs();
    randomize_frame();
    build_expected();
    send_pixels(NPIX, 30, 300);
    flush();
    checks++;
    if (got_conv.size() != exp_q.size() || bad_valid != 0) begin
      errors++;
      $display("FAIL gaps_count: got %0d (%0d while disabled), required %0d (0)",
               got_conv.size(), bad_valid, exp_q.size());
    end
    for (int i = 0; i < got_conv.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_conv[i] != exp_q[i] || got_relu[i] != ((exp_q[i] < 0) ? 0 : exp_q[i])) begin
        errors++;
        $display("FAIL gaps_val[%0d]: conv %0d relu %0d, required conv %0d", i, got_conv[i], got_relu[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_midframe_reset();
    randomize_frame();
    send_pixels(400, 10, -1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.conv_out !== 20'sd0 || bus.relu_out !== 20'sd0 || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: conv=%0d relu=%0d valid=%b, required 0 0 0",
               bus.conv_out, bus.relu_out, bus.valid_out);
    end
    step();
    rst_n = 1'b1;
    step();
    clear_obs();
    randomize_frame();
    build_expected();
    send_pixels(NPIX, 0, -1);
    flush();
    checks++;
    if (got_conv.size() != OUTS) begin
      errors++;
      $display("FAIL midreset_count: got %0d, required %0d", got_conv.size(), OUTS);
    end
    for (int i = 0; i < got_conv.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_conv[i] != exp_q[i]) begin
        errors++;
        $display("FAIL midreset_val[%0d]: got %0d, required %0d", i, got_conv[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    randomize_frame();
    build_expected();
    send_pixels(NPIX, 0, -1);
    for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(255));
    build_expected();
    send_pixels(NPIX, 0, -1);
    flush();
    checks++;
    if (got_conv.size() != 2 * OUTS) begin
      errors++;
      $display("FAIL b2b_count: got %0d, required %0d", got_conv.size(), 2 * OUTS);
    end
    for (int i = 0; i < got_conv.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_conv[i] != exp_q[i]) begin
        errors++;
        $display("FAIL b2b_val[%0d]: got %0d, required %0d", i, got_conv[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_ones_frame();
    test_extremes();
    test_ramp();
    test_gaps_enable();
    test_midframe_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv3x3_relu_pipeline.md
# conv3x3_relu_pipeline

Streaming 3x3 convolution front end for the CNN datapath: accepts a raster-order 8-bit unsigned image, one pixel per clock, forms every valid 3x3 window, applies one signed 3x3 filter plus bias, and emits the raw sum and its ReLU. It sits between the pixel source and the pooling/feature-map stage. It covers the line-buffer, convolution-unit and ReLU functions as one block. A 28x28 frame yields 26x26 = 676 outputs.

## Interface
- IMG_WIDTH, 28: pixels per row; also the row count, since frames are square.
- DATA_WIDTH, 8: pixel width, unsigned.
- WEIGHT_WIDTH, 8: weight and bias width, two's complement.
- ACC_WIDTH, 20: accumulator and output width, signed.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  global enable. When low, all state holds and valid_out is forced low.
- pixel_in  in  DATA_WIDTH  incoming pixel.
- pixel_valid  in  1  pixel_in is accepted on an edge where enable && pixel_valid.
- weights  in  9*WEIGHT_WIDTH  flattened taps; w_k = weights[8k+7:8k] for k = 0..8.
- bias  in  WEIGHT_WIDTH  signed bias.
- conv_out  out  ACC_WIDTH  registered signed convolution result.
- relu_out  out  ACC_WIDTH  combinational ReLU of conv_out.
- valid_out  out  1  one-cycle strobe per output; conv_out is valid while it is high.

## Operation
- Storage: two row buffers of IMG_WIDTH pixels each, plus a 3x3 shift window. An accepted pixel shifts into the window's bottom row. The pixels at the same column from the two previous rows shift into the middle and top rows.
- Position tracking: column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_WIDTH-1).
  - col advances on each accepted pixel.
  - row advances when col wraps.
  - After the last pixel of a frame, both counters return to 0, so back-to-back frames need no reset.
- Window ordering: window[0..2] is the top row, left to right; window[3..5] the middle row; window[6..8] the bottom row. window[8] is the pixel just accepted.
- Window validity: a window is valid when the accepted pixel had row >= 2 and col >= 2. No windows are formed across row boundaries.
- Arithmetic:
  - Each pixel is zero-extended to a signed value before multiplication.
  - sum = Σ_{k=0..8} window[k]*w_k + sign-extended bias, computed exactly at ACC_WIDTH.
  - The range with the defaults is [-293888, 291592], so no overflow or saturation occurs.
- ReLU: relu_out = 0 when conv_out is negative (MSB = 1); otherwise relu_out = conv_out.
- enable low: counters, buffers, window and output registers all hold, and no pixel is accepted. Outputs resume without loss when enable returns high.

## Timing
- Reset (rst_n low, asynchronous): counters, row buffers, window, conv_out and valid_out all clear to 0, so relu_out = 0. After reset the next accepted pixel is row 0, col 0. A reset mid-frame discards the partial frame.
- Latency: a pixel accepted at edge N completes its window at edge N. conv_out and valid_out update at edge N+1 (one register stage).
- valid_out:
  - It is high for exactly one cycle per valid window.
  - It is low on cycles with no accepted pixel, so gaps in pixel_valid produce gaps in the output.
- Throughput: one output per clock when pixel_valid is held high.
- For continuous streaming of a 28x28 frame, the last output appears one clock after the last pixel.
- Weights and bias are sampled on the accept edge and must be stable during a frame.

## Test plan
- All-zero 28x28 frame, stock filter (w = 9, 11, -2, 1, -2, -11, -17, -9, -8; bias = -10), continuous valid → exactly 676 valid_out pulses, each with conv_out = -10 and relu_out = 0.
- All-ones frame, all weights = 1, bias = 0 → 676 outputs, each with conv_out = 9 and relu_out = 9. The first valid_out arrives one clock after accepting pixel (row 2, col 2), i.e. pixel index 58.
- Extremes:
  - Pixels 255, weights 127, bias 127 → conv_out = 291592.
  - Pixels 255, weights -128, bias -128 → conv_out = -293888 and relu_out = 0.
- Ramp frame with pixel = col, weights = (0,0,0,0,0,0,0,0,1), bias = 0 → outputs in raster order; the j-th output of each row equals j+2 (values 2..27); 676 outputs total.
- Random pixel_valid gaps, plus an enable-low interval mid-frame → still exactly 676 outputs; values match a software golden model; no valid_out during gaps or while enable is low.
- Assert rst_n mid-frame, then stream a full frame → all outputs clear immediately; exactly 676 outputs from the new frame. Two back-to-back frames without reset → 1352 outputs.
